// File: rtl/sram_axi_slave.sv
// AXI4 slave front-end for a 64 KiB single-port SRAM macro.
// Serializes single-beat and INCR bursts (up to 16 beats) one transaction at a time.
module sram_axi_slave #(
    parameter int ID_W    = 8,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 4,
    parameter int SRAM_AW = 14
) (
    input  logic                  i_clk,
    input  logic                  i_rst,

    input  logic [ID_W-1:0]       i_arid,
    input  logic [ADDR_W-1:0]     i_araddr,
    input  logic [LEN_W-1:0]      i_arlen,
    input  logic [2:0]            i_arsize,
    input  logic [1:0]            i_arburst,
    input  logic                  i_arvalid,
    output logic                  o_arready,

    output logic [ID_W-1:0]       o_rid,
    output logic [DATA_W-1:0]     o_rdata,
    output logic [1:0]            o_rresp,
    output logic                  o_rlast,
    output logic                  o_rvalid,
    input  logic                  i_rready,

    input  logic [ID_W-1:0]       i_awid,
    input  logic [ADDR_W-1:0]     i_awaddr,
    input  logic [LEN_W-1:0]      i_awlen,
    input  logic [2:0]            i_awsize,
    input  logic [1:0]            i_awburst,
    input  logic                  i_awvalid,
    output logic                  o_awready,

    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_wstrb,
    input  logic                  i_wlast,
    input  logic                  i_wvalid,
    output logic                  o_wready,

    output logic [ID_W-1:0]       o_bid,
    output logic [1:0]            o_bresp,
    output logic                  o_bvalid,
    input  logic                  i_bready,

    output logic                  o_ceb,
    output logic                  o_web,
    output logic [DATA_W-1:0]     o_bweb,
    output logic [SRAM_AW-1:0]    o_a,
    output logic [DATA_W-1:0]     o_di,
    input  logic [DATA_W-1:0]     i_do
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        WRESP
    } state_t;

    state_t               r_state;
    logic [ID_W-1:0]      r_id;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_cnt;
    logic [SRAM_AW-1:0]   r_addr;
    logic                 r_err;

    state_t               w_stateNext;
    logic [ID_W-1:0]      w_idNext;
    logic [LEN_W-1:0]     w_lenNext;
    logic [LEN_W-1:0]     w_cntNext;
    logic [SRAM_AW-1:0]   w_addrNext;
    logic                 w_errNext;

    logic                 w_arHs;
    logic                 w_awHs;
    logic                 w_rHs;
    logic                 w_wHs;
    logic                 w_bHs;
    logic                 w_lastBeat;
    logic [SRAM_AW-1:0]   w_addrInc;

    // Size, burst type and the address bits outside the macro window carry no meaning here.
    logic                 w_unused;
    assign w_unused = ^{i_arsize, i_arburst, i_awsize, i_awburst,
                        i_araddr[ADDR_W-1:SRAM_AW+2], i_araddr[1:0],
                        i_awaddr[ADDR_W-1:SRAM_AW+2], i_awaddr[1:0]};

    assign o_arready = (r_state == IDLE)  & ~i_rst;
    assign o_awready = (r_state == IDLE)  & ~i_rst & ~i_arvalid;
    assign o_rvalid  = (r_state == READ)  & ~i_rst;
    assign o_wready  = (r_state == WRITE) & ~i_rst;
    assign o_bvalid  = (r_state == WRESP) & ~i_rst;

    assign w_arHs     = i_arvalid & o_arready;
    assign w_awHs     = i_awvalid & o_awready;
    assign w_rHs      = o_rvalid & i_rready;
    assign w_wHs      = i_wvalid & o_wready;
    assign w_bHs      = o_bvalid & i_bready;
    assign w_lastBeat = (r_cnt == r_len);
    assign w_addrInc  = r_addr + SRAM_AW'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_id    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_id    <= w_idNext;
            r_len   <= w_lenNext;
            r_cnt   <= w_cntNext;
            r_addr  <= w_addrNext;
            r_err   <= w_errNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_idNext    = r_id;
        w_lenNext   = r_len;
        w_cntNext   = r_cnt;
        w_addrNext  = r_addr;
        w_errNext   = r_err;

        o_rid   = '0;
        o_rdata = '0;
        o_rresp = 2'b00;
        o_rlast = 1'b0;
        o_bid   = '0;
        o_bresp = 2'b00;
        o_ceb   = 1'b1;
        o_web   = 1'b1;
        o_bweb  = '1;
        o_a     = '0;
        o_di    = '0;

        case (r_state)
            IDLE: begin
                if (w_arHs) begin
                    w_idNext    = i_arid;
                    w_lenNext   = i_arlen;
                    w_addrNext  = i_araddr[SRAM_AW+1:2];
                    w_cntNext   = '0;
                    w_stateNext = READ;
                    o_ceb       = 1'b0;
                    o_a         = i_araddr[SRAM_AW+1:2];
                end else if (w_awHs) begin
                    w_idNext    = i_awid;
                    w_lenNext   = i_awlen;
                    w_addrNext  = i_awaddr[SRAM_AW+1:2];
                    w_cntNext   = '0;
                    w_stateNext = WRITE;
                end
            end

            READ: begin
                o_rid   = r_id;
                o_rdata = i_do;
                o_rlast = w_lastBeat & o_rvalid;
                o_ceb   = 1'b0;
                // Re-reading the current word on a stall keeps DO, and so RDATA, stable.
                o_a     = w_rHs ? w_addrInc : r_addr;
                if (w_rHs) begin
                    w_addrNext = w_addrInc;
                    w_cntNext  = r_cnt + LEN_W'(1);
                    if (w_lastBeat) begin
                        w_stateNext = IDLE;
                    end
                end
            end

            WRITE: begin
                if (w_wHs) begin
                    o_ceb = 1'b0;
                    o_web = 1'b0;
                    o_a   = r_addr;
                    o_di  = i_wdata;
                    for (int i = 0; i < STRB_W; i++) begin
                        o_bweb[8*i +: 8] = {8{~i_wstrb[i]}};
                    end
                    w_addrNext = w_addrInc;
                    w_cntNext  = r_cnt + LEN_W'(1);
                    // AWLEN decides the burst end; WLAST only feeds the error flag.
                    if (w_lastBeat) begin
                        w_stateNext = WRESP;
                        w_errNext   = r_err | ~i_wlast;
                    end else if (i_wlast) begin
                        w_errNext = 1'b1;
                    end
                end
            end

            WRESP: begin
                o_bid   = r_id;
                o_bresp = r_err ? 2'b10 : 2'b00;
                if (w_bHs) begin
                    w_stateNext = IDLE;
                    w_errNext   = 1'b0;
                end
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_axi_slave.sv
// Self-checking bench for sram_axi_slave: behavioural SRAM macro, reference word array,
// directed scenarios followed by randomized write/read-back traffic.
module tb_sram_axi_slave;

    localparam int ID_W    = 8;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 4;
    localparam int SRAM_AW = 14;
    localparam int WORDS   = 1 << SRAM_AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [ID_W-1:0]    arId = '0;
    logic [ADDR_W-1:0]  arAddr = '0;
    logic [LEN_W-1:0]   arLen = '0;
    logic [2:0]         arSize = '0;
    logic [1:0]         arBurst = '0;
    logic               arValid = 1'b0;
    logic               arReady;
    logic [ID_W-1:0]    rId;
    logic [DATA_W-1:0]  rData;
    logic [1:0]         rResp;
    logic               rLast;
    logic               rValid;
    logic               rReady = 1'b0;
    logic [ID_W-1:0]    awId = '0;
    logic [ADDR_W-1:0]  awAddr = '0;
    logic [LEN_W-1:0]   awLen = '0;
    logic [2:0]         awSize = '0;
    logic [1:0]         awBurst = '0;
    logic               awValid = 1'b0;
    logic               awReady;
    logic [DATA_W-1:0]  wData = '0;
    logic [3:0]         wStrb = '0;
    logic               wLast = 1'b0;
    logic               wValid = 1'b0;
    logic               wReady;
    logic [ID_W-1:0]    bId;
    logic [1:0]         bResp;
    logic               bValid;
    logic               bReady = 1'b0;
    logic               sramCeb;
    logic               sramWeb;
    logic [DATA_W-1:0]  sramBweb;
    logic [SRAM_AW-1:0] sramA;
    logic [DATA_W-1:0]  sramDi;
    logic [DATA_W-1:0]  sramDo = '0;

    int checks = 0;
    int errors = 0;

    sram_axi_slave #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .SRAM_AW(SRAM_AW)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_arid(arId), .i_araddr(arAddr), .i_arlen(arLen), .i_arsize(arSize),
        .i_arburst(arBurst), .i_arvalid(arValid), .o_arready(arReady),
        .o_rid(rId), .o_rdata(rData), .o_rresp(rResp), .o_rlast(rLast),
        .o_rvalid(rValid), .i_rready(rReady),
        .i_awid(awId), .i_awaddr(awAddr), .i_awlen(awLen), .i_awsize(awSize),
        .i_awburst(awBurst), .i_awvalid(awValid), .o_awready(awReady),
        .i_wdata(wData), .i_wstrb(wStrb), .i_wlast(wLast), .i_wvalid(wValid),
        .o_wready(wReady),
        .o_bid(bId), .o_bresp(bResp), .o_bvalid(bValid), .i_bready(bReady),
        .o_ceb(sramCeb), .o_web(sramWeb), .o_bweb(sramBweb), .o_a(sramA),
        .o_di(sramDi), .i_do(sramDo)
    );

    // Behavioural macro: 1-cycle read latency, bit-masked writes, one-word backdoor load port.
    logic [DATA_W-1:0]  sramMem [WORDS];
    logic [DATA_W-1:0]  refMem  [WORDS];
    logic               fillDone = 1'b0;
    logic               loadEn = 1'b0;
    logic [SRAM_AW-1:0] loadAddr = '0;
    logic [DATA_W-1:0]  loadData = '0;
    int                 writeCount = 0;

    function automatic logic [31:0] initPattern(input int i);
        return (32'h9E37_79B9 * (i + 1)) ^ (i << 7);
    endfunction

    always @(posedge clk) begin
        if (!fillDone) begin
            for (int i = 0; i < WORDS; i++) sramMem[i] <= initPattern(i);
            fillDone <= 1'b1;
        end else if (loadEn) begin
            sramMem[loadAddr] <= loadData;
        end else if (!sramCeb) begin
            if (!sramWeb) begin
                sramMem[sramA] <= (sramMem[sramA] & sramBweb) | (sramDi & ~sramBweb);
                writeCount <= writeCount + 1;
            end else begin
                sramDo <= sramMem[sramA];
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preloadWord(input logic [SRAM_AW-1:0] idx, input logic [31:0] data);
        @(negedge clk);
        loadEn = 1'b1;
        loadAddr = idx;
        loadData = data;
        refMem[idx] = data;
        @(negedge clk);
        loadEn = 1'b0;
    endtask

    // Presents one address request and checks that it is accepted this cycle.
    task automatic applyStimulus(input bit isWrite, input logic [31:0] addr,
                                 input int len, input logic [7:0] id);
        @(negedge clk);
        rReady = 1'b0;
        bReady = 1'b0;
        wValid = 1'b0;
        if (isWrite) begin
            awValid = 1'b1; awAddr = addr; awLen = LEN_W'(len); awId = id;
            awSize = 3'($urandom_range(7)); awBurst = 2'($urandom_range(3));
        end else begin
            arValid = 1'b1; arAddr = addr; arLen = LEN_W'(len); arId = id;
            arSize = 3'($urandom_range(7)); arBurst = 2'($urandom_range(3));
        end
        #1;
        if (isWrite) begin
            checkOutput("awready", awReady, 1);
        end else begin
            checkOutput("arready", arReady, 1);
            checkOutput("ar_sram_ceb", sramCeb, 0);
            checkOutput("ar_sram_web", sramWeb, 1);
            checkOutput("ar_sram_addr", sramA, addr[15:2]);
        end
    endtask

    // stallMode: 0 always ready, 1 ready pattern 1,0,0 repeating, 2 random.
    task automatic readBurst(input logic [31:0] addr, input int len,
                             input logic [7:0] id, input int stallMode);
        logic [SRAM_AW-1:0] base;
        logic [SRAM_AW-1:0] idx;
        int beat;
        int cyc;
        base = addr[15:2];
        applyStimulus(0, addr, len, id);
        beat = 0;
        cyc = 0;
        while (beat <= len && cyc < 200) begin
            @(negedge clk);
            arValid = 1'b0;
            case (stallMode)
                0: rReady = 1'b1;
                1: rReady = (cyc % 3 == 0);
                default: rReady = 1'($urandom_range(1));
            endcase
            #1;
            if (cyc == 0) checkOutput("rvalid_latency", rValid, 1);
            if (rValid) begin
                idx = base + SRAM_AW'(beat);
                checkOutput("rdata", rData, refMem[idx]);
                checkOutput("rid", rId, id);
                checkOutput("rresp", rResp, 0);
                checkOutput("rlast", rLast, (beat == len));
                if (rReady) beat++;
            end
            cyc++;
        end
        if (beat <= len) checkOutput("read_timeout", 0, 1);
    endtask

    // wlastMode: 0 correct, 1 never asserted, 2 also on first beat, 3 random.
    task automatic writeBurst(input logic [31:0] addr, input int len, input logic [7:0] id,
                              input int gapPct, input int wlastMode, input bit doAw,
                              input bit useFixed, input logic [31:0] fixData,
                              input logic [3:0] fixStrb);
        logic [SRAM_AW-1:0] base;
        logic [SRAM_AW-1:0] idx;
        logic [31:0] mask;
        bit expErr;
        int beat;
        int cyc;
        int startCount;
        int delay;
        base = addr[15:2];
        if (doAw) applyStimulus(1, addr, len, id);
        startCount = writeCount;
        expErr = 0;
        beat = 0;
        cyc = 0;
        while (beat <= len && cyc < 300) begin
            @(negedge clk);
            awValid = 1'b0;
            wValid = ($urandom_range(99) >= gapPct);
            wData = useFixed ? fixData : $urandom;
            wStrb = useFixed ? fixStrb : 4'($urandom_range(15));
            case (wlastMode)
                0: wLast = (beat == len);
                1: wLast = 1'b0;
                2: wLast = (beat == len) || (beat == 0);
                default: wLast = 1'($urandom_range(1));
            endcase
            #1;
            checkOutput("wready", wReady, 1);
            if (wValid) begin
                idx = base + SRAM_AW'(beat);
                mask = '1;
                for (int b = 0; b < 4; b++) if (wStrb[b]) mask[8*b +: 8] = 8'h00;
                checkOutput("w_sram_ceb", sramCeb, 0);
                checkOutput("w_sram_web", sramWeb, 0);
                checkOutput("w_sram_addr", sramA, idx);
                checkOutput("w_sram_di", sramDi, wData);
                checkOutput("w_sram_bweb", sramBweb, mask);
                for (int b = 0; b < 4; b++) if (wStrb[b]) refMem[idx][8*b +: 8] = wData[8*b +: 8];
                if (beat == len) expErr = expErr | !wLast;
                else if (wLast) expErr = 1;
                beat++;
            end else begin
                checkOutput("gap_no_access", sramCeb, 1);
            end
            cyc++;
        end
        if (beat <= len) checkOutput("write_timeout", 0, 1);
        delay = $urandom_range(2);
        for (int d = 0; d <= delay; d++) begin
            @(negedge clk);
            wValid = 1'b0;
            wLast = 1'b0;
            bReady = (d == delay);
            #1;
            checkOutput("bvalid", bValid, 1);
            checkOutput("bid", bId, id);
            checkOutput("bresp", bResp, expErr ? 2'b10 : 2'b00);
        end
        @(negedge clk);
        bReady = 1'b0;
        #1;
        checkOutput("bvalid_drop", bValid, 0);
        checkOutput("write_count", writeCount - startCount, len + 1);
        for (int k = 0; k <= len; k++) begin
            idx = base + SRAM_AW'(k);
            checkOutput("sram_contents", sramMem[idx], refMem[idx]);
        end
    endtask

    initial begin
        logic [31:0] rAddr;
        int rLen;
        for (int i = 0; i < WORDS; i++) refMem[i] = initPattern(i);

        $display("[TB] reset state");
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_arready", arReady, 0);
        checkOutput("rst_awready", awReady, 0);
        checkOutput("rst_wready", wReady, 0);
        checkOutput("rst_rvalid", rValid, 0);
        checkOutput("rst_rlast", rLast, 0);
        checkOutput("rst_bvalid", bValid, 0);
        checkOutput("rst_rdata", rData, 0);
        checkOutput("rst_rid", rId, 0);
        checkOutput("rst_bid", bId, 0);
        checkOutput("rst_bresp", bResp, 0);
        checkOutput("rst_ceb", sramCeb, 1);
        checkOutput("rst_web", sramWeb, 1);
        checkOutput("rst_bweb", sramBweb, 32'hFFFF_FFFF);
        checkOutput("rst_a", sramA, 0);
        checkOutput("rst_di", sramDi, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("idle_arready", arReady, 1);
        checkOutput("idle_awready", awReady, 1);

        $display("[TB] single read");
        preloadWord(14'h0010, 32'hDEAD_BEEF);
        readBurst(32'h0000_0040, 0, 8'h15, 0);

        $display("[TB] burst read with backpressure");
        readBurst(32'h0000_0100, 3, 8'h2A, 1);

        $display("[TB] strobed write");
        preloadWord(14'h0020, 32'hAABB_CCDD);
        writeBurst(32'h0000_0080, 0, 8'h5C, 0, 0, 1, 1, 32'h1122_3344, 4'b0101);
        checkOutput("strobe_merge", sramMem[14'h0020], 32'hAA22_CC44);

        $display("[TB] write burst with wrap and gaps");
        writeBurst(32'h0000_FFF8, 3, 8'h61, 40, 0, 1, 0, 0, 0);
        readBurst(32'h0000_FFF8, 3, 8'h62, 2);

        $display("[TB] protocol errors");
        writeBurst(32'h0000_0400, 2, 8'h71, 0, 1, 1, 0, 0, 0);
        writeBurst(32'h0000_0410, 1, 8'h72, 0, 0, 1, 0, 0, 0);
        writeBurst(32'h0000_0420, 3, 8'h73, 20, 2, 1, 0, 0, 0);

        $display("[TB] simultaneous AR and AW");
        @(negedge clk);
        arValid = 1'b1; arAddr = 32'h0000_0040; arLen = '0; arId = 8'h21;
        awValid = 1'b1; awAddr = 32'h0000_0200; awLen = 4'd1; awId = 8'h33;
        #1;
        checkOutput("arb_arready", arReady, 1);
        checkOutput("arb_awready", awReady, 0);
        @(negedge clk);
        arValid = 1'b0;
        rReady = 1'b1;
        #1;
        checkOutput("arb_rvalid", rValid, 1);
        checkOutput("arb_rdata", rData, refMem[14'h0010]);
        checkOutput("arb_rid", rId, 8'h21);
        checkOutput("arb_rlast", rLast, 1);
        checkOutput("arb_awready_busy", awReady, 0);
        @(negedge clk);
        rReady = 1'b0;
        #1;
        checkOutput("arb_awready_after", awReady, 1);
        writeBurst(32'h0000_0200, 1, 8'h33, 0, 0, 0, 0, 0, 0);

        $display("[TB] reset mid-burst");
        applyStimulus(0, 32'h0000_0300, 7, 8'h44);
        @(negedge clk);
        arValid = 1'b0;
        rReady = 1'b1;
        #1;
        checkOutput("mid_beat0", rData, refMem[14'h00C0]);
        @(negedge clk);
        #1;
        checkOutput("mid_beat1_valid", rValid, 1);
        checkOutput("mid_beat1", rData, refMem[14'h00C1]);
        rst = 1'b1;
        @(negedge clk);
        rReady = 1'b0;
        #1;
        checkOutput("mid_rst_rvalid", rValid, 0);
        checkOutput("mid_rst_arready", arReady, 0);
        checkOutput("mid_rst_ceb", sramCeb, 1);
        rst = 1'b0;
        #1;
        checkOutput("mid_idle_arready", arReady, 1);
        readBurst(32'h0000_0300, 7, 8'h45, 2);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 8; t++) begin
            rAddr = $urandom;
            rLen = $urandom_range(15);
            writeBurst(rAddr, rLen, 8'($urandom), $urandom_range(50), 3, 1, 0, 0, 0);
            readBurst(rAddr, rLen, 8'($urandom), 2);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_axi_slave.md
# sram_axi_slave

AXI4 responder that connects one 64 KiB single-port SRAM macro (IM or DM) to a slave port of the on-chip AXI bridge. It serves the requests issued by the CPU-side master FSMs: single-beat and INCR bursts of up to 16 word beats for reads and writes, with byte strobes. Transactions are serialized, one in flight at a time. Read data is streamed from the SRAM's 1-cycle-latency output without an extra buffer.

## Interface
- ID_W, 8, slave-side ID width (4-bit master ID plus 4-bit master index)
- ADDR_W, 32, AXI address width
- DATA_W, 32, data width; STRB_W = DATA_W/8
- LEN_W, 4, burst length field width
- SRAM_AW, 14, SRAM word-address width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  ID_W/ADDR_W/LEN_W/3/2/1  read address; ARREADY  out  1
- RID  out  ID_W; RDATA  out  DATA_W; RRESP  out  2; RLAST  out  1; RVALID  out  1; RREADY  in  1
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  as AR; AWREADY  out  1
- WDATA  in  DATA_W; WSTRB  in  STRB_W; WLAST  in  1; WVALID  in  1; WREADY  out  1
- BID  out  ID_W; BRESP  out  2; BVALID  out  1; BREADY  in  1
- CEB  out  1  SRAM chip enable, active-low
- WEB  out  1  SRAM write enable, active-low (1 = read)
- BWEB  out  DATA_W  per-bit write mask, active-low
- A  out  SRAM_AW  SRAM word address
- DI  out  DATA_W  SRAM write data; DO  in  DATA_W  SRAM read data, valid one cycle after a read access

## Operation
- FSM states: IDLE, READ, WRITE, WRESP. Reset enters IDLE.
- IDLE:
  - ARREADY = 1; AWREADY = ~ARVALID, so reads win a simultaneous request.
  - On an AR handshake: latch ARID, ARLEN, and the word address ADDR[15:2]; clear the beat counter; go to READ.
  - Also on an AR handshake: drive CEB=0, WEB=1, A=ARADDR[15:2] in the same cycle.
  - On an AW handshake: latch AWID, AWLEN, and the word address; clear the beat counter; go to WRITE.
- READ:
  - RVALID=1, RDATA=DO, RID=latched ID, RRESP=2'b00, RLAST=(cnt==len).
  - SRAM access every cycle: CEB=0, WEB=1. A = addr+1 on an R handshake, otherwise A = addr, so DO always holds the current beat.
  - On an R handshake: addr increments and cnt increments. If RLAST is also set, go to IDLE.
- WRITE:
  - WREADY=1.
  - On a W handshake: CEB=0, WEB=0, A=addr, DI=WDATA, BWEB byte i = {8{~WSTRB[i]}}; addr and cnt increment.
  - When no W handshake occurs: CEB=1 (no SRAM access).
  - On the beat where cnt==len: go to WRESP. Set the error flag if WLAST is 0 on that beat.
  - The error flag is also set if WLAST=1 arrives on any earlier beat.
  - Burst length is governed by AWLEN alone; WLAST is only checked.
- WRESP:
  - BVALID=1, BID=latched ID, BRESP = error ? 2'b10 (SLVERR) : 2'b00.
  - On a B handshake: go to IDLE and clear the error flag.
- Arithmetic:
  - Word address is SRAM_AW bits and wraps 0x3FFF→0x0000 within a burst.
  - cnt is LEN_W bits.
  - ARBURST/AWBURST and ARSIZE/AWSIZE are ignored; every access is treated as INCR, 4-byte.
- Outside their states, SRAM outputs idle at CEB=1, WEB=1, BWEB all-ones, A=0, DI=0.

## Timing
- Reset values: ARREADY, AWREADY, WREADY, RVALID, RLAST and BVALID are 0; RDATA, RID, RRESP, BID and BRESP are 0; SRAM outputs are at idle values.
- The readies are gated by ~rst.
- Read latency: AR handshake in cycle T gives RVALID=1 in cycle T+1. Back-to-back beats run at 1 per cycle while RREADY=1.
- Write: AW handshake in T gives WREADY in T+1. The SRAM write occurs in the W handshake cycle. BVALID rises the cycle after the final beat.
- Turnaround: the earliest next address handshake is the cycle after the final R or B handshake (IDLE costs 1 cycle).
- An RREADY stall holds RDATA stable, since A is re-issued with the same address.
- A WVALID gap produces no SRAM access and no counter change.
- rst asserted mid-transaction: the FSM returns to IDLE at the next edge with no response issued, and all valids drop.

## Test plan
- Single read: preload word 0x10 = 0xDEADBEEF; AR with addr 0x40, len 0, ID 0x15 → one beat with RDATA 0xDEADBEEF, RID 0x15, RLAST=1, RRESP 0, RVALID at T+1.
- Burst read with backpressure: addr 0x100, len 3, RREADY toggling 1,0,0,1… → 4 beats of words 0x40–0x43 in order, each stable while stalled, RLAST only on beat 4.
- Strobed write: AW addr 0x80, len 0; W 0x11223344 with WSTRB 0b0101 onto old 0xAABBCCDD → SRAM word 0x20 = 0xAA22CC44; BRESP 0, BID matches AWID.
- Write burst with wrap and gaps: AW addr 0xFFF8, len 3, WVALID gaps → words 0x3FFE, 0x3FFF, 0x0000, 0x0001 written; no extra writes occur during the gaps.
- Protocol error and arbitration:
  - WLAST missing on beat len → BRESP 2'b10; the next write gets BRESP 0.
  - ARVALID and AWVALID asserted in the same cycle in IDLE → read is accepted first, write after it.
- Reset mid-burst: assert rst during beat 2 of a len-7 read → RVALID=0 and ARREADY=0 during reset, IDLE afterwards, and a new read completes normally.
